quantum_scheduler: RTL

Parametrised preemptive round-robin scheduler for the multiprogrammed processor. It counts retired instructions against a run-time programmable quantum, saves the running process's resume PC into an internal table, and selects the next ready process. It also handles I/O blocking and process termination, then issues a one-cycle dispatch to the PC-update logic. It sits beside the control unit and replaces the fixed single-quantum counter. It supports up to NPROC processes with per-process ready/blocked state.

---
 rtl/sched_pkg.sv | 20 ++
 rtl/rr_pick.sv | 28 ++
 rtl/quantum_scheduler.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sched_pkg.sv
// Shared types and defaults for the preemptive round-robin process scheduler.
package sched_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_READY,
    SLOT_RUNNING,
    SLOT_BLOCKED
  } slot_state_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SELECT,
    ST_DISPATCH
  } fsm_state_e;

  localparam int Q_DEFAULT = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of mask at or after start, wrapping.
module rr_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] pid
);

  logic [W-1:0] idx;

  // N is a power of two, so W-bit addition wraps the search modulo N.
  always_comb begin
    found = 1'b0;
    pid   = start;
    idx   = start;
    for (int i = 0; i < N; i++) begin
      idx = start + W'(i);
      if (!found && mask[idx]) begin
        found = 1'b1;
        pid   = idx;
      end
    end
  end

endmodule

// File: rtl/quantum_scheduler.sv
// Preemptive round-robin scheduler: quantum expiry, I/O blocking, termination and
// a one-cycle dispatch pulse carrying the chosen process's saved PC.
module quantum_scheduler #(
  parameter int NPROC     = 8,
  parameter int PC_W      = 32,
  parameter int Q_W       = 8,
  parameter int Q_DEFAULT = sched_pkg::Q_DEFAULT,
  parameter int PID_W     = $clog2(NPROC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             retire,
  input  logic [PC_W-1:0]  resume_pc,
  input  logic             io_req,
  input  logic             io_done,
  input  logic [PID_W-1:0] io_pid,
  input  logic             proc_end,
  input  logic             create,
  input  logic [PID_W-1:0] create_pid,
  input  logic [PC_W-1:0]  create_pc,
  input  logic             q_load,
  input  logic [Q_W-1:0]   q_value,
  output logic             switch_valid,
  output logic [PC_W-1:0]  next_pc,
  output logic [PID_W-1:0] cur_pid,
  output logic             idle,
  output logic             all_done
);

  import sched_pkg::*;

  fsm_state_e      state, state_nxt;
  slot_state_e     slot_state [NPROC];
  logic [PC_W-1:0] saved_pc   [NPROC];
  logic [Q_W-1:0]  quantum, quantum_pend, count;
  logic [PID_W-1:0] sel_pid, pick_pid;
  logic             pick_found;
  logic [NPROC-1:0] ready_mask, ready_soon, free_mask;
  logic             in_run, do_end, do_io, do_exp, trigger;

  rr_pick #(.N(NPROC), .W(PID_W)) u_pick (
    .mask  (ready_mask),
    .start (cur_pid + PID_W'(1)),
    .found (pick_found),
    .pid   (pick_pid)
  );

  // ready_soon includes slots made READY on this edge, so IDLE leaves without an extra cycle.
  always_comb begin
    ready_mask = '0;
    ready_soon = '0;
    free_mask  = '0;
    for (int i = 0; i < NPROC; i++) begin
      ready_mask[i] = (slot_state[i] == SLOT_READY);
      free_mask[i]  = (slot_state[i] == SLOT_FREE);
      ready_soon[i] = ready_mask[i]
                    | (create && create_pid == PID_W'(i) && slot_state[i] == SLOT_FREE)
                    | (io_done && io_pid == PID_W'(i) && slot_state[i] == SLOT_BLOCKED);
    end
  end

  assign in_run   = (state == ST_RUN);
  assign do_end   = in_run && proc_end;
  assign do_io    = in_run && io_req && !proc_end;
  assign do_exp   = in_run && retire && !proc_end && !io_req && (count == quantum - Q_W'(1));
  assign trigger  = do_end || do_io || do_exp;
  assign idle     = (state == ST_IDLE);
  assign all_done = &free_mask;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (|ready_soon) state_nxt = ST_SELECT;
      ST_RUN:      if (trigger) state_nxt = ST_SELECT;
      ST_SELECT:   state_nxt = pick_found ? ST_DISPATCH : ST_IDLE;
      ST_DISPATCH: state_nxt = ST_RUN;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Slot updates below are mutually exclusive by the slot's current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      quantum      <= Q_W'(Q_DEFAULT);
      quantum_pend <= Q_W'(Q_DEFAULT);
      count        <= '0;
      sel_pid      <= '0;
      cur_pid      <= '0;
      next_pc      <= '0;
      switch_valid <= 1'b0;
      for (int i = 0; i < NPROC; i++) begin
        slot_state[i] <= SLOT_FREE;
        saved_pc[i]   <= '0;
      end
    end else begin
      state        <= state_nxt;
      switch_valid <= 1'b0;
      if (q_load)
        quantum_pend <= (q_value == '0) ? Q_W'(1) : q_value;
      if (state == ST_SELECT)
        sel_pid <= pick_pid;
      if (in_run && retire && count != '1)
        count <= count + Q_W'(1);
      if (state == ST_DISPATCH) begin
        count        <= '0;
        quantum      <= quantum_pend;
        cur_pid      <= sel_pid;
        next_pc      <= saved_pc[sel_pid];
        switch_valid <= 1'b1;
      end
      for (int i = 0; i < NPROC; i++) begin
        if (create && create_pid == PID_W'(i) && slot_state[i] == SLOT_FREE) begin
          slot_state[i] <= SLOT_READY;
          saved_pc[i]   <= create_pc;
        end else if (io_done && io_pid == PID_W'(i) && slot_state[i] == SLOT_BLOCKED) begin
          slot_state[i] <= SLOT_READY;
        end else if (state == ST_DISPATCH && sel_pid == PID_W'(i)) begin
          slot_state[i] <= SLOT_RUNNING;
        end else if (trigger && cur_pid == PID_W'(i)) begin
          if (do_end) begin
            slot_state[i] <= SLOT_FREE;
          end else begin
            slot_state[i] <= do_io ? SLOT_BLOCKED : SLOT_READY;
            saved_pc[i]   <= resume_pc;
          end
        end
      end
    end
  end

endmodule
